// File: rtl/wasca_mul_pkg.sv
// Shared definitions for the Nios II multiply unit: mode encoding and
// helpers telling which operands a mode treats as signed.
package wasca_mul_pkg;

    localparam int MODE_W = 2;

    // Mode encoding as presented on in_mode.
    localparam logic [MODE_W-1:0] ENC_MUL    = 2'd0;
    localparam logic [MODE_W-1:0] ENC_MULXUU = 2'd1;
    localparam logic [MODE_W-1:0] ENC_MULXSU = 2'd2;
    localparam logic [MODE_W-1:0] ENC_MULXSS = 2'd3;

    typedef enum logic [MODE_W-1:0] {
        MUL    = ENC_MUL,
        MULXUU = ENC_MULXUU,
        MULXSU = ENC_MULXSU,
        MULXSS = ENC_MULXSS
    } mul_mode_t;

    // Operand A is interpreted as two's complement in MULXSU and MULXSS.
    function automatic logic mode_signed_a(input mul_mode_t mode);
        return (mode == MULXSU) || (mode == MULXSS);
    endfunction

    // Operand B is interpreted as two's complement only in MULXSS.
    function automatic logic mode_signed_b(input mul_mode_t mode);
        return (mode == MULXSS);
    endfunction

endpackage

// File: rtl/wasca_mul_slice.sv
// Registered SW x SW unsigned multiplier, one DSP-sized partial product.
// Loads on en, clears asynchronously on reset_n low.
module wasca_mul_slice #(
    parameter int SW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic [SW-1:0]   a,
    input  logic [SW-1:0]   b,
    output logic [2*SW-1:0] p
);

    // Capture the zero-extended product when the owning stage accepts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p <= '0;
        end else if (en) begin
            p <= {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
        end
    end

endmodule

// File: rtl/wasca_nios2_mul_unit.sv
// Two-stage pipelined integer multiplier for the Nios II datapath.
// Stage 1 registers slice partial products, stage 2 sums, applies signed
// correction to the high word and holds the result for the consumer.
// Build option: define WASCA_MUL_HIGH_EN to build the fourth partial product
// and support MULXUU/MULXSU/MULXSS; without it those modes return 0 and flag
// out_illegal. WIDTH must be even and at least 8.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on pipeline occupancy and out_ready, never
// on in_valid; out_valid and its payload stay fixed until out_ready is seen.
module wasca_nios2_mul_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);

    import wasca_mul_pkg::*;

    localparam int SLICE = WIDTH / 2;

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_advance;
    logic             accept;
    mul_mode_t        s1_mode;
    logic [TAG_W-1:0] s1_tag;

    logic [WIDTH-1:0] pp_ll;
    logic [WIDTH-1:0] pp_lh;
    logic [WIDTH-1:0] pp_hl;

    logic [WIDTH-1:0] s2_result;
    logic             s2_illegal;

    // S1 moves forward whenever S2 is empty or is handing its result over.
    assign s1_advance = s1_valid && (!s2_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;
    assign accept     = in_valid && in_ready;
    assign out_valid  = s2_valid;
    assign busy       = s1_valid || s2_valid;

    wasca_mul_slice #(.SW(SLICE)) u_pp_ll (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .a       (in_src1[SLICE-1:0]),
        .b       (in_src2[SLICE-1:0]),
        .p       (pp_ll)
    );

    wasca_mul_slice #(.SW(SLICE)) u_pp_lh (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .a       (in_src1[SLICE-1:0]),
        .b       (in_src2[WIDTH-1:SLICE]),
        .p       (pp_lh)
    );

    wasca_mul_slice #(.SW(SLICE)) u_pp_hl (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .a       (in_src1[WIDTH-1:SLICE]),
        .b       (in_src2[SLICE-1:0]),
        .p       (pp_hl)
    );

`ifdef WASCA_MUL_HIGH_EN
    logic [WIDTH-1:0]   pp_hh;
    logic [WIDTH-1:0]   s1_src1;
    logic [WIDTH-1:0]   s1_src2;
    logic [2*WIDTH-1:0] full;
    logic [WIDTH-1:0]   hi_corr;

    wasca_mul_slice #(.SW(SLICE)) u_pp_hh (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .a       (in_src1[WIDTH-1:SLICE]),
        .b       (in_src2[WIDTH-1:SLICE]),
        .p       (pp_hh)
    );

    // Raw operands ride along with the partial products; stage 2 needs their
    // signs and full values to correct the unsigned high word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_src1 <= '0;
            s1_src2 <= '0;
        end else if (accept) begin
            s1_src1 <= in_src1;
            s1_src2 <= in_src2;
        end
    end

    // Sum all four partial products, then turn the unsigned high word into
    // the signed/mixed high word by subtracting the other operand.
    always_comb begin
        full = {{WIDTH{1'b0}}, pp_ll}
             + ({{WIDTH{1'b0}}, pp_lh} << SLICE)
             + ({{WIDTH{1'b0}}, pp_hl} << SLICE)
             + {pp_hh, {WIDTH{1'b0}}};
        hi_corr = full[2*WIDTH-1:WIDTH];
        if (mode_signed_a(s1_mode) && s1_src1[WIDTH-1]) begin
            hi_corr = hi_corr - s1_src2;
        end
        if (mode_signed_b(s1_mode) && s1_src2[WIDTH-1]) begin
            hi_corr = hi_corr - s1_src1;
        end
        s2_result  = (s1_mode == MUL) ? full[WIDTH-1:0] : hi_corr;
        s2_illegal = 1'b0;
    end
`else
    logic [WIDTH-1:0] low_word;

    // Only the low word is reachable: sums at WIDTH bits drop the carries
    // that would belong to the missing high word.
    always_comb begin
        low_word   = pp_ll + (pp_lh << SLICE) + (pp_hl << SLICE);
        s2_result  = (s1_mode == MUL) ? low_word : '0;
        s2_illegal = (s1_mode != MUL);
    end
`endif

    // Stage 1 bookkeeping: occupancy, mode and tag of the operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MUL;
            s1_tag   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_mode <= mul_mode_t'(in_mode);
                s1_tag  <= in_tag;
            end
        end
    end

    // Stage 2 output register: loads from S1, holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid    <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (s1_advance) begin
            s2_valid    <= 1'b1;
            out_result  <= s2_result;
            out_tag     <= s1_tag;
            out_illegal <= s2_illegal;
        end else if (out_ready) begin
            s2_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wasca_nios2_mul_unit.sv
// Bench for wasca_nios2_mul_unit: directed corner cases, a backpressured
// stream, mid-flight reset and random traffic against a 64-bit reference.
module tb_wasca_nios2_mul_unit;

    localparam int W  = 32;
    localparam int TW = 5;
    localparam int PW = 1 + TW + W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [W-1:0]  in_src1;
    logic [W-1:0]  in_src2;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          out_illegal;
    logic          busy;

    logic [PW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            or_mode = 0;
    int            cyc = 0;

    // clock / reset block
    always #5 clk = ~clk;

    wasca_nios2_mul_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_src1     (in_src1),
        .in_src2     (in_src2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    // Reference: exact product of the operands as the mode interprets them.
    function automatic logic [PW-1:0] model(input logic [1:0] m, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [TW-1:0] t);
        logic [2*W-1:0] ea, eb, p;
        logic [W-1:0]   r;
        logic           ill;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        if (m == 2'd2 || m == 2'd3) ea = {{W{a[W-1]}}, a};
        if (m == 2'd3)              eb = {{W{b[W-1]}}, b};
        p   = ea * eb;
        r   = (m == 2'd0) ? p[W-1:0] : p[2*W-1:W];
        ill = 1'b0;
`ifndef WASCA_MUL_HIGH_EN
        if (m != 2'd0) begin
            r   = '0;
            ill = 1'b1;
        end
`endif
        return {ill, t, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // out_ready driver: 0 always ready, 1 pattern 1,0,0, 2 random, 3 stalled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // driver tasks
    task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t);
        int   n;
        logic acc;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = m;
        in_src1  = a;
        in_src2  = b;
        in_tag   = t;
        n = 0;
        forever begin
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(model(m, a, b, t));
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: tag %0d never accepted", t);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // scoreboard monitor: occupancy invariants, stall stability, in-order results
    initial begin
        logic [PW-1:0] held, got, e;
        logic          stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                stall = 1'b0;
            end else begin
                got = {out_illegal, out_tag, out_result};
                if (stall) check("stall_hold", {out_valid, got}, {1'b1, held});
                check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
                check("busy", busy, exp_q.size() != 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h expected none", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", got, e);
                    end
                end
                stall = out_valid && !out_ready;
                held  = got;
            end
        end
    end

    // main sequence
    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_mode  = '0;
        in_src1  = '0;
        in_src2  = '0;
        in_tag   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        // latency with no backpressure
        or_mode = 0;
        send(2'd0, 32'h0001_2345, 32'h0001_0000, 5'd7);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        #1;
        check("lat_cycle2_valid", out_valid, 1);
        check("lat_value", {out_tag, out_result}, {5'd7, 32'h2345_0000});
        drain();

        // all-ones across every mode, then most-negative operands
        for (int m = 0; m < 4; m++) send(m[1:0], 32'hFFFF_FFFF, 32'hFFFF_FFFF, TW'(m));
        send(2'd3, 32'h8000_0000, 32'h8000_0000, 5'd10);
        send(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd11);
        send(2'd0, 32'h8000_0000, 32'h8000_0000, 5'd12);
        idle();
        drain();

        // back-to-back stream under 1,0,0 backpressure
        or_mode = 1;
        for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), pick(), pick(), TW'(i));
        idle();
        drain();

        // fill both stages, then reset mid-flight
        or_mode = 3;
        send(2'd0, 32'd3, 32'd5, 5'd1);
        send(2'd0, 32'd7, 32'd9, 5'd2);
        idle();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        or_mode = 0;
        repeat (5) @(negedge clk);
        send(2'd0, 32'd1234, 32'd5678, 5'd21);
        idle();
        drain();

        // random traffic with random backpressure and input gaps
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            send(2'($urandom_range(0, 3)), pick(), pick(), TW'($urandom));
        end
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
